// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave controller: FSM state encoding and
// default frame/response widths.
package spi_pkg;

    localparam int SPI_FRAME_BITS = 10;
    localparam int SPI_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

endpackage

// File: rtl/spi_bit_counter.sv
// Saturating up-counter used to track received frame bits and transmitted
// response bits. Clear wins over enable; o_done flags the terminal value.
module spi_bit_counter #(
    parameter int MAX_COUNT = 10,
    parameter int WIDTH     = $clog2(MAX_COUNT + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic             o_done
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Next count: clear, or step up until the terminal value and hold there
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en && (cnt_q != TERM)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register, async active-low reset
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_count = cnt_q;
    assign o_done  = (cnt_q == TERM);

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave protocol controller: deserializes {cmd[1:0], payload[7:0]} MOSI
// frames and serializes an 8-bit read response on MISO. A read is two
// transactions: an address frame (READ_ADD) then a data frame (READ_DATA)
// whose response comes from i_tx_data once i_tx_valid is seen.
// Optional macro SPI_FRAME_ERR_EN builds abort detection on o_frame_err.
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int FRAME_BITS = SPI_FRAME_BITS,
    parameter int DATA_BITS  = SPI_DATA_BITS,
    parameter int CNT_WIDTH  = $clog2(FRAME_BITS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ss_n,
    input  logic                  i_mosi,
    output logic                  o_miso,
    output logic [FRAME_BITS-1:0] o_rx_data,
    output logic                  o_rx_valid,
    input  logic [DATA_BITS-1:0]  i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_frame_err
);

    localparam int                   TX_CNT_WIDTH = $clog2(DATA_BITS + 1);
    localparam logic [CNT_WIDTH-1:0] RX_LAST      = CNT_WIDTH'(FRAME_BITS - 1);

    state_t                  state_q, state_d;
    logic                    rd_addr_seen_q, rd_addr_seen_d;
    logic [FRAME_BITS-1:0]   rx_sr_q, rx_sr_d;
    logic [DATA_BITS-1:0]    tx_sr_q, tx_sr_d;
    logic                    rx_pend_q, rx_pend_d;
    logic                    miso_q, miso_d;
    logic [FRAME_BITS-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;

    logic [CNT_WIDTH-1:0]    rx_cnt;
    logic                    rx_done;
    logic [TX_CNT_WIDTH-1:0] tx_cnt;
    logic                    tx_done;

    logic in_rx_state, cnt_clr, rx_shift, tx_active, tx_wait, tx_load, tx_en;

    // Phase decode shared by the counters and the datapath
    always_comb begin
        in_rx_state = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
        cnt_clr     = i_ss_n || (state_q == IDLE);
        rx_shift    = !i_ss_n && ((state_q == CHK_CMD) || (in_rx_state && !rx_done));
        // Transmit runs while tx_cnt is between load and terminal value
        tx_active   = (tx_cnt != '0) && !tx_done;
        // Response is accepted only once the data frame has been reported
        tx_wait     = !i_ss_n && (state_q == READ_DATA) && rx_done && !rx_pend_q
                      && (tx_cnt == '0);
        tx_load     = tx_wait && i_tx_valid;
        tx_en       = !i_ss_n && (tx_load || tx_active);
    end

    spi_bit_counter #(
        .MAX_COUNT (FRAME_BITS),
        .WIDTH     (CNT_WIDTH)
    ) u_rx_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (cnt_clr),
        .i_en    (rx_shift),
        .o_count (rx_cnt),
        .o_done  (rx_done)
    );

    spi_bit_counter #(
        .MAX_COUNT (DATA_BITS),
        .WIDTH     (TX_CNT_WIDTH)
    ) u_tx_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (cnt_clr),
        .i_en    (tx_en),
        .o_count (tx_cnt),
        .o_done  (tx_done)
    );

    // FSM next state and datapath next values
    always_comb begin
        state_d        = state_q;
        rd_addr_seen_d = rd_addr_seen_q;
        rx_sr_d        = rx_sr_q;
        tx_sr_d        = tx_sr_q;
        rx_data_d      = rx_data_q;
        miso_d         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!i_ss_n) state_d = CHK_CMD;
            end
            CHK_CMD: begin
                if (!i_mosi)             state_d = WRITE;
                else if (rd_addr_seen_q) state_d = READ_DATA;
                else                     state_d = READ_ADD;
            end
            default: ;
        endcase
        // Deselect aborts any transaction
        if (i_ss_n) state_d = IDLE;

        // Receive: MSB first, stop once the frame is complete
        if (rx_shift) rx_sr_d = {rx_sr_q[FRAME_BITS-2:0], i_mosi};
        rx_pend_d  = rx_shift && (rx_cnt == RX_LAST);
        rx_valid_d = rx_pend_q;
        if (rx_pend_q) rx_data_d = rx_sr_q;

        if ((state_q == READ_ADD) && rx_pend_q) rd_addr_seen_d = 1'b1;
        // Only a completed response retires the pending read address
        if ((state_q == READ_DATA) && tx_done)  rd_addr_seen_d = 1'b0;

        // Transmit: MSB goes out straight from the load, rest from the shifter
        if (tx_load) begin
            miso_d  = i_tx_data[DATA_BITS-1];
            tx_sr_d = {i_tx_data[DATA_BITS-2:0], 1'b0};
        end else if (tx_en) begin
            miso_d  = tx_sr_q[DATA_BITS-1];
            tx_sr_d = {tx_sr_q[DATA_BITS-2:0], 1'b0};
        end
    end

    // State and datapath registers, async active-low reset
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q        <= IDLE;
            rd_addr_seen_q <= 1'b0;
            rx_sr_q        <= '0;
            tx_sr_q        <= '0;
            rx_pend_q      <= 1'b0;
            miso_q         <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            rx_sr_q        <= rx_sr_d;
            tx_sr_q        <= tx_sr_d;
            rx_pend_q      <= rx_pend_d;
            miso_q         <= miso_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
        end
    end

    assign o_miso     = miso_q;
    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;

`ifdef SPI_FRAME_ERR_EN
    logic frame_err_q, frame_err_d;

    // Deselect during a partial frame or a partial response is an abort
    always_comb begin
        frame_err_d = i_ss_n && ((in_rx_state && (rx_cnt != '0) && !rx_done) || tx_active);
    end

    // Abort pulse register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign o_frame_err = frame_err_q;
`else
    assign o_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: frames pushed to a scoreboard queue are checked
// by an independent monitor on every o_rx_valid; directed checks cover MISO,
// state, aborts and async reset.
module tb_spi_slave_ctrl;
    import spi_pkg::*;

`ifdef SPI_FRAME_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_ss_n = 1'b1;
    logic       i_mosi = 1'b0;
    logic       o_miso;
    logic [9:0] o_rx_data;
    logic       o_rx_valid;
    logic [7:0] i_tx_data = 8'h00;
    logic       i_tx_valid = 1'b0;
    logic       o_frame_err;

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q[$];
    logic prev_v = 1'b0;

    spi_slave_ctrl dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ss_n      (i_ss_n),
        .i_mosi      (i_mosi),
        .o_miso      (o_miso),
        .o_rx_data   (o_rx_data),
        .o_rx_valid  (o_rx_valid),
        .i_tx_data   (i_tx_data),
        .i_tx_valid  (i_tx_valid),
        .o_frame_err (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    // Scoreboard monitor: every rx_valid pops one expected frame
    always @(negedge i_clk) begin
        if (i_rst && o_rx_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rx_unexpected: got data=%h, required no rx_valid", o_rx_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if (o_rx_data !== e) begin
                    bad++;
                    $display("FAIL rx_data: got %h, required %h", o_rx_data, e);
                end
            end
            total++;
            if (prev_v) begin
                bad++;
                $display("FAIL rx_pulse_width: got 2+ cycles, required 1");
            end
        end
        prev_v = o_rx_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input state_t exp);
        chk(name, 32'(dut.state_q), 32'(exp));
    endtask

    // Drop ss_n, then drive nbits of f MSB first; miso must stay quiet
    task automatic send_frame(input logic [9:0] f, input int nbits, input state_t st);
        @(negedge i_clk);
        i_ss_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge i_clk);
            if (i == 1) chk_state("frame_state", st);
            chk("miso_rx_quiet", 32'(o_miso), 32'd0);
            i_mosi = f[9-i];
        end
    endtask

    task automatic end_txn();
        @(negedge i_clk);
        i_ss_n = 1'b1;
        i_mosi = 1'b0;
        @(negedge i_clk);
        chk_state("idle_after_ss", IDLE);
        chk("miso_after_ss", 32'(o_miso), 32'd0);
    endtask

    // Bounded wait for rx_valid; returns on the negedge where it is seen
    task automatic wait_rx();
        int n;
        logic got;
        n = 0;
        got = 1'b0;
        while (!got && n < 30) begin
            @(negedge i_clk);
            if (o_rx_valid) got = 1'b1;
            n++;
        end
        chk("rx_valid_timeout", 32'(got), 32'd1);
    endtask

    // Offer a response two cycles after rx_valid, check the first nchk bits
    task automatic tx_start(input logic [7:0] d, input int nchk);
        wait_rx();
        @(negedge i_clk);
        @(negedge i_clk);
        i_tx_valid = 1'b1;
        i_tx_data  = d;
        for (int k = 0; k < nchk; k++) begin
            @(negedge i_clk);
            i_tx_valid = 1'b0;
            chk("miso_bit", 32'(o_miso), 32'(d[7-k]));
        end
    endtask

    initial begin
        // Reset held with ss_n low and mosi toggling
        i_ss_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            i_mosi = ~i_mosi;
        end
        chk_state("rst_state", IDLE);
        chk("rst_miso", 32'(o_miso), 32'd0);
        chk("rst_rx_data", 32'(o_rx_data), 32'd0);
        chk("rst_rx_valid", 32'(o_rx_valid), 32'd0);
        chk("rst_frame_err", 32'(o_frame_err), 32'd0);
        chk("rst_rd_addr_seen", 32'(dut.rd_addr_seen_q), 32'd0);
        i_ss_n = 1'b1;
        i_mosi = 1'b0;
        i_rst  = 1'b1;
        repeat (3) @(negedge i_clk);
        chk_state("post_rst_idle", IDLE);

        // Write frame with tx_valid held high throughout (must be ignored)
        i_tx_valid = 1'b1;
        i_tx_data  = 8'hFF;
        exp_q.push_back(10'h0A5);
        send_frame(10'b00_1010_0101, 10, WRITE);
        @(negedge i_clk);
        chk("wr_valid_early", 32'(o_rx_valid), 32'd0);
        @(negedge i_clk);
        chk("wr_valid_latency", 32'(o_rx_valid), 32'd1);
        @(negedge i_clk);
        chk("wr_valid_fall", 32'(o_rx_valid), 32'd0);
        chk("wr_miso_quiet", 32'(o_miso), 32'd0);
        chk("wr_rx_data_hold", 32'(o_rx_data), 32'h0A5);
        i_tx_valid = 1'b0;
        end_txn();

        // Read address frame
        exp_q.push_back(10'h23C);
        send_frame(10'b10_0011_1100, 10, READ_ADD);
        wait_rx();
        end_txn();
        chk("rd_addr_seen_set", 32'(dut.rd_addr_seen_q), 32'd1);

        // Read data frame, full response 8'hC3
        exp_q.push_back(10'h300);
        send_frame(10'b11_0000_0000, 10, READ_DATA);
        tx_start(8'hC3, 8);
        @(negedge i_clk);
        chk("miso_after_tx", 32'(o_miso), 32'd0);
        chk("rd_addr_seen_clr", 32'(dut.rd_addr_seen_q), 32'd0);
        end_txn();

        // Third read goes back to the address phase
        exp_q.push_back(10'h2AB);
        send_frame(10'b10_1010_1011, 10, READ_ADD);
        wait_rx();
        end_txn();

        // Write aborted after 5 bits
        send_frame(10'b00_1111_1111, 5, WRITE);
        @(negedge i_clk);
        i_ss_n = 1'b1;
        @(negedge i_clk);
        chk_state("abort_idle", IDLE);
        chk("abort_frame_err", 32'(o_frame_err), 32'(ERR_EN));
        chk("abort_no_valid", 32'(o_rx_valid), 32'd0);
        @(negedge i_clk);
        chk("abort_err_pulse", 32'(o_frame_err), 32'd0);
        chk("abort_keeps_addr", 32'(dut.rd_addr_seen_q), 32'd1);

        // Read data aborted by ss_n after 3 response bits
        exp_q.push_back(10'h3F0);
        send_frame(10'b11_1111_0000, 10, READ_DATA);
        tx_start(8'hA5, 3);
        i_ss_n = 1'b1;
        @(negedge i_clk);
        chk("txabort_miso", 32'(o_miso), 32'd0);
        chk("txabort_frame_err", 32'(o_frame_err), 32'(ERR_EN));
        chk("txabort_keeps_addr", 32'(dut.rd_addr_seen_q), 32'd1);
        @(negedge i_clk);
        chk("txabort_err_pulse", 32'(o_frame_err), 32'd0);

        // Read data interrupted by async reset mid-transmit
        exp_q.push_back(10'h30F);
        send_frame(10'b11_0000_1111, 10, READ_DATA);
        tx_start(8'h5A, 3);
        #2 i_rst = 1'b0;
        #1;
        chk("arst_miso", 32'(o_miso), 32'd0);
        chk_state("arst_state", IDLE);
        chk("arst_rd_addr_seen", 32'(dut.rd_addr_seen_q), 32'd0);
        chk("arst_rx_data", 32'(o_rx_data), 32'd0);
        @(negedge i_clk);
        i_ss_n = 1'b1;
        i_rst  = 1'b1;

        // After reset a read frame starts at the address phase again
        exp_q.push_back(10'h201);
        send_frame(10'b10_0000_0001, 10, READ_ADD);
        wait_rx();
        end_txn();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

endmodule
